// File: rtl/cmp_window_stats_pkg.sv
// Shared types and defaults for the comparator window statistics block:
// FSM state encodings, the comparator sample struct and a one-hot helper.
package cmp_window_stats_pkg;

  localparam int unsigned CMP_WIN_LEN_DEF = 8;
  localparam int unsigned CMP_CNT_W_DEF   = 4;

  typedef enum logic [1:0] {
    CMP_ST_IDLE   = 2'd0,
    CMP_ST_ACCUM  = 2'd1,
    CMP_ST_REPORT = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_sample_t;

  function automatic logic is_onehot(input cmp_sample_t s);
    return (s.gt ^ s.eq ^ s.lt) && !(s.gt && s.eq && s.lt);
  endfunction

endpackage

// File: rtl/cmp_window_stats_if.sv
// Sample-in / snapshot-out bundle of cmp_window_stats. The block itself
// connects through the slave modport; the producer/consumer side uses master.
interface cmp_window_stats_if
  import cmp_window_stats_pkg::*;
#(
  parameter int unsigned CNT_W = CMP_CNT_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] max_eq_run;
  logic             onehot_err;

  modport master (
    output in_valid, cmp_gt, cmp_eq, cmp_lt, clear, out_ready,
    input  in_ready, out_valid, gt_cnt, eq_cnt, lt_cnt, max_eq_run, onehot_err
  );

  modport slave (
    input  in_valid, cmp_gt, cmp_eq, cmp_lt, clear, out_ready,
    output in_ready, out_valid, gt_cnt, eq_cnt, lt_cnt, max_eq_run, onehot_err
  );

endinterface

// File: rtl/cmp_window_stats_sat_counter.sv
// Saturating up-counter with synchronous clear. Exposes the value it will
// hold after the next edge so callers can snapshot it on that same edge.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] nxt
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] q;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    nxt = q;
    if (clr) begin
      nxt = '0;
    end else if (inc && (q != MAX)) begin
      nxt = q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/cmp_window_stats.sv
// Counts comparator outcomes over WIN_LEN accepted samples and presents a
// registered snapshot. Optional eq-run tracking under CMP_STREAK_DETECT_EN.
module cmp_window_stats
  import cmp_window_stats_pkg::*;
#(
  parameter int unsigned WIN_LEN = CMP_WIN_LEN_DEF,
  parameter int unsigned CNT_W   = CMP_CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  cmp_window_stats_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

  cmp_state_e       state;
  cmp_state_e       state_nxt;
  cmp_sample_t      smp;
  logic             one_hot;
  logic             accept;
  logic             handshake;
  logic             last_smp;
  logic             cnt_clr;
  logic [CNT_W-1:0] smp_cnt;
  logic [CNT_W-1:0] gt_nxt;
  logic [CNT_W-1:0] eq_nxt;
  logic [CNT_W-1:0] lt_nxt;

  assign smp       = {bus.cmp_gt, bus.cmp_eq, bus.cmp_lt};
  assign one_hot   = is_onehot(smp);
  // clear outranks both the accept and the snapshot handshake
  assign accept    = bus.in_valid && bus.in_ready && !bus.clear;
  assign handshake = bus.out_valid && bus.out_ready && !bus.clear;
  assign last_smp  = accept && (smp_cnt == LAST_IDX);
  assign cnt_clr   = bus.clear || handshake;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CMP_ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = CMP_ST_IDLE;
    end else begin
      unique case (state)
        CMP_ST_IDLE, CMP_ST_ACCUM: begin
          if (last_smp)    state_nxt = CMP_ST_REPORT;
          else if (accept) state_nxt = CMP_ST_ACCUM;
        end
        CMP_ST_REPORT: if (handshake) state_nxt = CMP_ST_IDLE;
        default:       state_nxt = CMP_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state != CMP_ST_REPORT);
    bus.out_valid = (state == CMP_ST_REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      smp_cnt <= '0;
    end else if (accept) begin
      smp_cnt <= smp_cnt + CNT_W'(1);
    end
  end

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(accept && one_hot && smp.gt), .nxt(gt_nxt)
  );
  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(accept && one_hot && smp.eq), .nxt(eq_nxt)
  );
  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(accept && one_hot && smp.lt), .nxt(lt_nxt)
  );

  // Snapshot captures the post-edge counts so the final sample is included.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gt_cnt <= '0;
      bus.eq_cnt <= '0;
      bus.lt_cnt <= '0;
    end else if (last_smp) begin
      bus.gt_cnt <= gt_nxt;
      bus.eq_cnt <= eq_nxt;
      bus.lt_cnt <= lt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.onehot_err <= 1'b0;
    end else if (accept && !one_hot) begin
      bus.onehot_err <= 1'b1;
    end
  end

`ifdef CMP_STREAK_DETECT_EN
  logic             eq_only;
  logic [CNT_W-1:0] run_nxt;
  logic [CNT_W-1:0] run_max;
  logic [CNT_W-1:0] run_max_nxt;

  assign eq_only     = one_hot && smp.eq;
  assign run_max_nxt = (run_nxt > run_max) ? run_nxt : run_max;

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk(clk), .rst(rst),
    .clr(cnt_clr || (accept && !eq_only)),
    .inc(accept && eq_only),
    .nxt(run_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      run_max <= '0;
    end else begin
      run_max <= run_max_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.max_eq_run <= '0;
    end else if (last_smp) begin
      bus.max_eq_run <= run_max_nxt;
    end
  end
`else
  assign bus.max_eq_run = '0;
`endif

endmodule

// File: tb/tb_cmp_window_stats.sv
// Directed bench for cmp_window_stats (WIN_LEN=8, CNT_W=4); expected eq-run
// values follow CMP_STREAK_DETECT_EN.
module tb_cmp_window_stats;

  localparam logic [2:0] GT  = 3'b100;
  localparam logic [2:0] EQ  = 3'b010;
  localparam logic [2:0] LT  = 3'b001;
  localparam logic [2:0] GE  = 3'b110;
  localparam logic [2:0] NON = 3'b000;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  logic [2:0] w1 [8] = '{EQ, GT, EQ, EQ, GT, GT, EQ, LT};
  logic [2:0] w3 [8] = '{EQ, EQ, EQ, GE, EQ, EQ, EQ, EQ};
  logic [2:0] w4 [8] = '{GT, LT, LT, EQ, GT, LT, EQ, LT};
  logic [2:0] w6 [8] = '{EQ, EQ, GT, EQ, EQ, EQ, LT, EQ};
  logic [2:0] w5 [8] = '{EQ, EQ, EQ, EQ, EQ, EQ, EQ, EQ};

  always #5 clk = ~clk;

  cmp_window_stats_if #(.CNT_W(4)) bus ();

  cmp_window_stats #(.WIN_LEN(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else passed++;
  endtask

  function automatic logic [31:0] run_exp(input int n);
`ifdef CMP_STREAK_DETECT_EN
    return n;
`else
    return (n > 0) ? 0 : 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] s);
    bus.in_valid = 1'b1;
    {bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} = s;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Feeds one full window; out_valid must stay low until the 8th accept.
  task automatic send_window(input string tag, input logic [2:0] seq [8]);
    logic early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(seq[i]);
      if (i < 7 && (bus.out_valid || !bus.in_ready)) early = 1'b1;
    end
    check({tag, " early_report"}, early, 0);
    check({tag, " out_valid"}, bus.out_valid, 1);
    check({tag, " in_ready"}, bus.in_ready, 0);
  endtask

  task automatic check_snap(input string tag, input int g, input int e, input int l, input int r);
    check({tag, " gt_cnt"}, bus.gt_cnt, g);
    check({tag, " eq_cnt"}, bus.eq_cnt, e);
    check({tag, " lt_cnt"}, bus.lt_cnt, l);
    check({tag, " max_eq_run"}, bus.max_eq_run, run_exp(r));
  endtask

  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " post_hs out_valid"}, bus.out_valid, 0);
    check({tag, " post_hs in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    logic stable;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.cmp_gt    = 1'b0;
    bus.cmp_eq    = 1'b0;
    bus.cmp_lt    = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst onehot_err", bus.onehot_err, 0);
    check_snap("rst", 0, 0, 0, 0);

    // Window 1: 3 gt, 4 eq, 1 lt, longest eq run 2
    send_window("w1", w1);
    check_snap("w1", 3, 4, 1, 2);

    // Hold REPORT with traffic on the input; nothing may be accepted
    stable = 1'b1;
    bus.in_valid = 1'b1;
    {bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} = GT;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!bus.out_valid || bus.in_ready || bus.gt_cnt != 4'd3 ||
          bus.eq_cnt != 4'd4 || bus.lt_cnt != 4'd1) stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("hold stable", stable, 1);
    take("w1");
    check_snap("w1 persist", 3, 4, 1, 2);
    check("w1 onehot_err", bus.onehot_err, 0);

    // Window 3: one gt+eq sample among 7 eq
    send_window("w3", w3);
    check_snap("w3", 0, 7, 0, 4);
    check("w3 onehot_err", bus.onehot_err, 1);
    take("w3");
    check("w3 err sticky", bus.onehot_err, 1);

    // clear after 5 accepts, with a sample offered in the same cycle
    for (int i = 0; i < 5; i++) drive(EQ);
    bus.clear = 1'b1;
    drive(GT);
    bus.clear = 1'b0;
    check("clr out_valid", bus.out_valid, 0);
    check("clr in_ready", bus.in_ready, 1);
    send_window("w4", w4);
    check_snap("w4", 2, 2, 4, 1);

    // clear during REPORT drops the snapshot but keeps the count outputs
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr_rep out_valid", bus.out_valid, 0);
    check("clr_rep in_ready", bus.in_ready, 1);
    check_snap("clr_rep", 2, 2, 4, 1);
    check("clr_rep onehot_err", bus.onehot_err, 1);

    // Window 6: eq,eq,gt,eq,eq,eq,lt,eq
    send_window("w6", w6);
    check_snap("w6", 1, 6, 1, 3);
    take("w6");

    // Reset while in REPORT
    send_window("w5", w5);
    check_snap("w5", 0, 8, 0, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rep out_valid", bus.out_valid, 0);
    check("rst_rep in_ready", bus.in_ready, 1);
    check("rst_rep onehot_err", bus.onehot_err, 0);
    check_snap("rst_rep", 0, 0, 0, 0);

    // Window with an idle gap and an all-zero sample last
    for (int i = 0; i < 3; i++) drive(GT);
    tick();
    check("gap out_valid", bus.out_valid, 0);
    for (int i = 0; i < 4; i++) drive(GT);
    check("w7 pre out_valid", bus.out_valid, 0);
    drive(NON);
    check("w7 out_valid", bus.out_valid, 1);
    check_snap("w7", 7, 0, 0, 0);
    check("w7 onehot_err", bus.onehot_err, 1);
    take("w7");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
